// File: rtl/solar_sweep_tracker_if.sv
// Bus bundle for the solar sweep tracker: button levels and ADC stream in,
// servo step pulses, status and positions out.
interface solar_sweep_tracker_if #(
   parameter int ADC_W = 12,
   parameter int POS_W = 8
);
   logic             BTN_L, BTN_R, BTN_U, BTN_D, BTN_C;
   logic [ADC_W-1:0] ADC_DATA;
   logic             ADC_VALID;
   logic             SERVO_L, SERVO_R, SERVO_U, SERVO_D;
   logic [2:0]       STAT;
   logic             BUSY, DONE;
   logic [POS_W-1:0] H_POS, V_POS;
   logic [ADC_W-1:0] MAX_VAL;

   // Stimulus side (buttons, ADC front end)
   modport master (
      output BTN_L, BTN_R, BTN_U, BTN_D, BTN_C, ADC_DATA, ADC_VALID,
      input  SERVO_L, SERVO_R, SERVO_U, SERVO_D, STAT, BUSY, DONE,
             H_POS, V_POS, MAX_VAL
   );

   // Tracker side
   modport slave (
      input  BTN_L, BTN_R, BTN_U, BTN_D, BTN_C, ADC_DATA, ADC_VALID,
      output SERVO_L, SERVO_R, SERVO_U, SERVO_D, STAT, BUSY, DONE,
             H_POS, V_POS, MAX_VAL
   );
endinterface

// File: rtl/solar_sweep_tracker.sv
// Two-axis sun tracker: manual jog plus a calibration that sweeps each axis
// down to 0 while recording the ADC peak, then steps back up to the peak.
// Optional macro SWEEP_AUTO_RETRACK_EN: start a calibration automatically
// after RETRACK_TICKS idle step ticks in manual mode.
module solar_sweep_tracker #(
   parameter int ADC_W         = 12,
   parameter int POS_W         = 8,
   parameter int H_STEPS       = 180,
   parameter int V_STEPS       = 90,
   parameter int STEP_DIV      = 100000,
   parameter int RETRACK_TICKS = 60000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   solar_sweep_tracker_if.slave  bus
);
   localparam int               PW       = $clog2(STEP_DIV);
   localparam logic [PW-1:0]    DIV_LAST = PW'(STEP_DIV - 1);
   localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_STEPS - 1);
   localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_STEPS - 1);
   localparam logic [POS_W-1:0] H_MID    = POS_W'(H_STEPS / 2);
   localparam logic [POS_W-1:0] V_MID    = POS_W'(V_STEPS / 2);

   typedef enum logic [2:0] {
      S_MAN  = 3'd0,
      S_HSW  = 3'd1,
      S_HMAX = 3'd2,
      S_VSW  = 3'd3,
      S_VMAX = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             btn_c_q;
   logic [ADC_W-1:0] sample_q;
   logic [ADC_W-1:0] best_val_q, best_val_d;
   logic [POS_W-1:0] best_pos_q, best_pos_d;
   logic [ADC_W-1:0] max_val_q, max_val_d;
   logic [POS_W-1:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
   logic [ADC_W-1:0] cand_val;
   logic [POS_W-1:0] cand_pos;
   logic             tick, c_rise, start;
   logic             srv_l, srv_r, srv_u, srv_d, done;

   assign tick   = (presc_q == DIV_LAST);
   assign c_rise = bus.BTN_C & ~btn_c_q;

`ifdef SWEEP_AUTO_RETRACK_EN
   localparam int IW = $clog2(RETRACK_TICKS + 1);
   logic [IW-1:0] idle_q, idle_d;
   logic          any_btn, idle_hit;

   assign any_btn = bus.BTN_L | bus.BTN_R | bus.BTN_U | bus.BTN_D | bus.BTN_C;

   // Idle tick counter: any button or being outside MAN restarts it
   always_comb begin
      idle_d   = idle_q;
      idle_hit = 1'b0;
      if (state_q != S_MAN || any_btn) begin
         idle_d = '0;
      end else if (tick) begin
         if (idle_q == IW'(RETRACK_TICKS - 1)) begin
            idle_hit = 1'b1;
            idle_d   = '0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   // Idle counter register
   always_ff @(posedge CLK) begin
      if (!RST_N) idle_q <= '0;
      else        idle_q <= idle_d;
   end

   assign start = c_rise | idle_hit;
`else
   assign start = c_rise;
`endif

   // Next state, step pulses and peak tracking
   always_comb begin
      state_d    = state_q;
      h_pos_d    = h_pos_q;
      v_pos_d    = v_pos_q;
      best_val_d = best_val_q;
      best_pos_d = best_pos_q;
      max_val_d  = max_val_q;
      cand_val   = best_val_q;
      cand_pos   = best_pos_q;
      srv_l      = 1'b0;
      srv_r      = 1'b0;
      srv_u      = 1'b0;
      srv_d      = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_MAN: begin
            if (start) begin
               // No jog on the start cycle; sweep begins from the current spot
               state_d    = S_HSW;
               best_val_d = '0;
               best_pos_d = h_pos_q;
            end else if (tick) begin
               srv_l = bus.BTN_L & ~bus.BTN_R & (h_pos_q != '0);
               srv_r = bus.BTN_R & ~bus.BTN_L & (h_pos_q < H_LAST);
               srv_d = bus.BTN_D & ~bus.BTN_U & (v_pos_q != '0);
               srv_u = bus.BTN_U & ~bus.BTN_D & (v_pos_q < V_LAST);
            end
         end
         S_HSW: begin
            if (c_rise) begin
               state_d = S_MAN;
            end else if (tick) begin
               // Strict compare: on a tie the earlier (higher) position wins
               if (sample_q > best_val_q) begin
                  cand_val = sample_q;
                  cand_pos = h_pos_q;
               end
               best_val_d = cand_val;
               best_pos_d = cand_pos;
               if (h_pos_q == '0) begin
                  max_val_d = cand_val;
                  state_d   = S_HMAX;
               end else begin
                  srv_l = 1'b1;
               end
            end
         end
         S_HMAX: begin
            if (c_rise) begin
               state_d = S_MAN;
            end else if (tick) begin
               if (h_pos_q == best_pos_q) begin
                  state_d    = S_VSW;
                  best_val_d = '0;
                  best_pos_d = v_pos_q;
               end else begin
                  srv_r = 1'b1;
               end
            end
         end
         S_VSW: begin
            if (c_rise) begin
               state_d = S_MAN;
            end else if (tick) begin
               if (sample_q > best_val_q) begin
                  cand_val = sample_q;
                  cand_pos = v_pos_q;
               end
               best_val_d = cand_val;
               best_pos_d = cand_pos;
               if (v_pos_q == '0) begin
                  max_val_d = cand_val;
                  state_d   = S_VMAX;
               end else begin
                  srv_d = 1'b1;
               end
            end
         end
         S_VMAX: begin
            if (c_rise) begin
               state_d = S_MAN;
            end else if (tick) begin
               if (v_pos_q == best_pos_q) begin
                  max_val_d = best_val_q;
                  done      = 1'b1;
                  state_d   = S_MAN;
               end else begin
                  srv_u = 1'b1;
               end
            end
         end
         default: state_d = S_MAN;
      endcase
      if (srv_l) h_pos_d = h_pos_q - 1'b1;
      if (srv_r) h_pos_d = h_pos_q + 1'b1;
      if (srv_d) v_pos_d = v_pos_q - 1'b1;
      if (srv_u) v_pos_d = v_pos_q + 1'b1;
   end

   // Prescaler restarts on every state change so the first step lands a full period later
   always_comb begin
      presc_d = presc_q + 1'b1;
      if (state_d != state_q || tick) presc_d = '0;
   end

   // State, positions, peak and sample registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= S_MAN;
         presc_q    <= '0;
         btn_c_q    <= 1'b0;
         sample_q   <= '0;
         best_val_q <= '0;
         best_pos_q <= '0;
         max_val_q  <= '0;
         h_pos_q    <= H_MID;
         v_pos_q    <= V_MID;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         btn_c_q    <= bus.BTN_C;
         if (bus.ADC_VALID) sample_q <= bus.ADC_DATA;
         best_val_q <= best_val_d;
         best_pos_q <= best_pos_d;
         max_val_q  <= max_val_d;
         h_pos_q    <= h_pos_d;
         v_pos_q    <= v_pos_d;
      end
   end

   assign bus.SERVO_L = srv_l;
   assign bus.SERVO_R = srv_r;
   assign bus.SERVO_U = srv_u;
   assign bus.SERVO_D = srv_d;
   assign bus.DONE    = done;
   assign bus.STAT    = state_q;
   assign bus.BUSY    = (state_q == S_HSW) || (state_q == S_HMAX) ||
                        (state_q == S_VSW) || (state_q == S_VMAX);
   assign bus.H_POS   = h_pos_q;
   assign bus.V_POS   = v_pos_q;
   assign bus.MAX_VAL = max_val_q;
endmodule

// File: doc/solar_sweep_tracker.md
# solar_sweep_tracker

Parametrised two-axis sun-tracking controller that replaces the external counter/FSM pair with internal servo position counters, a step prescaler and an ADC peak search. It sits between the debounced push-buttons, the ADC sample stream (photodiode voltage) and the servo step drivers. Modes are manual jog, horizontal sweep, horizontal return-to-max, vertical sweep and vertical return-to-max. A centre-button press can start or abort a calibration.

## Interface
- ADC_W, 12, ADC sample width
- POS_W, 8, position counter width; H_STEPS and V_STEPS must be ≤ 2^POS_W
- H_STEPS, 180, number of horizontal positions (0..H_STEPS-1)
- V_STEPS, 90, number of vertical positions (0..V_STEPS-1)
- STEP_DIV, 100000, CLK cycles per servo step tick (≥2)
- RETRACK_TICKS, 60000, idle ticks before an automatic recalibration (used only with the macro)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous, active-low reset
- BTN_L, BTN_R, BTN_U, BTN_D, BTN_C  in  1 each  debounced buttons, level
- ADC_DATA  in  ADC_W  photodiode sample
- ADC_VALID  in  1  ADC_DATA qualifier; sample latched when high
- SERVO_L, SERVO_R, SERVO_U, SERVO_D  out  1 each  one-cycle step pulses
- STAT  out  3  state: 0 MAN, 1 H_SWEEP, 2 H_MAX, 3 V_SWEEP, 4 V_MAX
- BUSY  out  1  high when STAT≠MAN
- DONE  out  1  one-cycle pulse on completion of V_MAX
- H_POS, V_POS  out  POS_W each  current servo positions
- MAX_VAL  out  ADC_W  peak sample found on the last completed axis

## Operation
- Reset values: STAT=MAN; H_POS=H_STEPS/2; V_POS=V_STEPS/2; prescaler=0; last sample=0; best value/position=0; MAX_VAL=0; all pulses, BUSY and DONE low.
- Prescaler counts 0..STEP_DIV-1. The tick is asserted in the cycle where the count equals STEP_DIV-1. The prescaler clears on every state change.
- The last sample register loads ADC_DATA on every cycle with ADC_VALID=1.
- SERVO_L decrements H_POS, SERVO_R increments it. SERVO_D decrements V_POS, SERVO_U increments it. Each pulse and its position update occur in the same tick cycle.
- MAN:
  - On a tick, BTN_L with H_POS>0 pulses SERVO_L; BTN_R with H_POS<H_STEPS-1 pulses SERVO_R.
  - L and R pressed together produce no pulse. U/D follow the same rules against V_STEPS-1.
  - A BTN_C rising edge moves the FSM to H_SWEEP. On entry, the best value clears to 0 and the best position is set to the current position.
- H_SWEEP, on a tick:
  - If the last sample is strictly greater than the best value, best value ← sample and best position ← H_POS.
  - Then: if H_POS==0, MAX_VAL ← best value and the FSM goes to H_MAX. Otherwise SERVO_L pulses.
  - Ties keep the earlier (higher) position.
- H_MAX, on a tick: if H_POS==best position, go to V_SWEEP (best value and position re-initialised). Otherwise SERVO_R pulses.
- V_SWEEP and V_MAX mirror H_SWEEP and H_MAX on V_POS, using SERVO_D and SERVO_U. V_MAX completion loads MAX_VAL, pulses DONE and returns to MAN.
- A BTN_C rising edge in any calibration state aborts to MAN. No pulse is issued that cycle, and positions are retained.
- Buttons other than BTN_C are ignored outside MAN.
- Illegal STAT values recover to MAN with all outputs low.

## Timing
- The BTN_C edge detector uses a 1-cycle registered previous value. The state changes on the clock edge after the edge is seen.
- The first step after any state entry occurs STEP_DIV cycles after entry.
- At most one horizontal and one vertical pulse per tick. Calibration states pulse only one axis.
- Full calibration from H_POS=h, V_POS=v takes (h+1+hbest+1+v+1+vbest+1)·STEP_DIV cycles, ±1 cycle for the BTN_C edge.
- RST_N low mid-sweep returns everything to reset values on the next edge.

## Configuration
- SWEEP_AUTO_RETRACK_EN defined:
  - In MAN, an idle counter increments on each tick while no button is high, and clears on any button or on leaving MAN.
  - Reaching RETRACK_TICKS starts H_SWEEP exactly as BTN_C does.
- Not defined: the idle counter is absent, RETRACK_TICKS is ignored, and only BTN_C starts a calibration.

## Test plan
(All scenarios use STEP_DIV=4, H_STEPS=8, V_STEPS=4.)
- Reset: RST_N low 2 cycles -> H_POS=4, V_POS=2, STAT=0, all pulses 0.
- Manual: hold BTN_L for 24 cycles -> 4 SERVO_L pulses spaced 4 cycles, H_POS stops at 0. Hold BTN_L+BTN_R -> no pulses.
- Calibration: ADC peak 0x800 at H_POS=2, other samples 0x100 -> 4 L pulses, STAT=2, 2 R pulses, H_POS=2, MAX_VAL=0x800. Vertical phase follows, then DONE pulse and STAT=0.
- Tie: equal peaks at H_POS=3 and 1 -> return to H_POS=3.
- Abort: BTN_C edge during H_SWEEP at H_POS=2 -> STAT=0 next cycle, H_POS stays 2, no further pulses.
- With SWEEP_AUTO_RETRACK_EN and RETRACK_TICKS=3, no buttons -> STAT=1 after 12 cycles in MAN. Pressing BTN_U at tick 2 restarts the idle count.
